nibble_alu_seq: RTL and testbench
=================================

Name: nibble_alu_seq

Overview:
- Parametrised, nibble-serial successor to the core 8-bit ALU datapath.
- Executes the eight SM83 accumulator operations on WIDTH-bit operands, one 4-bit nibble per clock, low nibble first.
- Produces result plus Z/N/H/C flags with a start/busy/done handshake.
- Sits beside the core ALU and serves 8-bit and 16-bit arithmetic micro-ops, e.g. ADD HL,rr style, without a second full-width adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values 4..32 and a multiple of 4. NIB = WIDTH/4 (derived, not overridable).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when idle
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- cin  in  1  carry/borrow in for ADC/SBC; latched on accepted start; ignored for other ops
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse; result and flags valid
- result  out  WIDTH  result register
- zero  out  1  Z flag
- negative  out  1  N flag (subtract)
- half_carry  out  1  H flag
- carry  out  1  C flag

Behaviour:
- Reset (nreset low, asynchronous): state IDLE, busy=0, done=0, result=0, zero=0, negative=0, half_carry=0, carry=0, nibble counter=0, latched operands=0. Takes effect immediately, mid-operation included: the operation is aborted and no done pulse follows.
- States:
  - IDLE: start=1 at edge E0 latches a, b, op, cin; sets busy=1, counter=0, internal carry = cin for ADC/SBC, else 0; next state RUN.
  - RUN: each edge computes nibble[counter] from the latched operands and the internal carry, writes it into result[4*counter+3:4*counter], updates the internal carry, and increments counter. The edge that writes nibble NIB-1 moves to DONE.
  - DONE: single cycle with done=1 and busy=0, then IDLE. A start in the DONE cycle is accepted, allowing back-to-back operations.
- Timing: start in cycle 0. busy is high in cycles 1..NIB. done is high in cycle NIB+1. Total latency is NIB+1 cycles.
- start while busy=1 is ignored; it is neither queued nor allowed to disturb the operation. Operand inputs may change freely after the accepting edge.
- Arithmetic:
  - ADD/ADC: nibble = a_n + b_n + c.
  - SUB/SBC/CP: nibble = a_n - b_n - c; internal carry is the borrow out.
  - All sums are computed 5 bits wide; bit 4 is the carry/borrow out.
- Flags, updated only on the final RUN edge (held at previous values during busy):
  - carry = carry/borrow out of nibble NIB-1 for ADD/ADC/SUB/SBC/CP; 0 for AND/XOR/OR.
  - half_carry = carry/borrow out of nibble 0 for arithmetic ops; 1 for AND; 0 for XOR/OR.
  - negative = 1 for SUB/SBC/CP, else 0.
  - zero = 1 if the full WIDTH-bit computed value is 0. For CP this is the difference, not the stored result.
- CP: result nibbles are rewritten with the latched a, so result = a at done; flags are as for SUB.
- result and flags hold their values after done until the next operation's writes. result nibbles change progressively during busy; consumers sample only on done.
- WIDTH=4 (NIB=1): a single RUN cycle; half_carry and carry are both taken from nibble 0.
- Wrap-around: results are modulo 2^WIDTH; no overflow flag.

Test Plan:
- WIDTH=8, ADD a=0x3A b=0xC6 -> done in cycle 3; result=0x00, Z=1 N=0 H=1 C=1; busy high cycles 1-2 only.
- WIDTH=8, OR a=0x5A b=0xA5, then AND a=0xF0 b=0x0F started in the done cycle -> first: 0xFF, Z0 N0 H0 C0; second accepted back-to-back: 0x00, Z1 N0 H1 C0.
- WIDTH=8, SUB a=0x10 b=0x01 -> 0x0F, Z0 N1 H1 C0. SBC a=0x00 b=0x00 cin=1 -> 0xFF, N1 H1 C1.
- WIDTH=8, CP a=0x42 b=0x42 -> result=0x42, Z1 N1 H0 C0. CP a=0x10 b=0x20 -> result=0x10, Z0 N1 H0 C1.
- WIDTH=16, ADC a=0xFFFF b=0x0000 cin=1 -> done in cycle 5; result=0x0000, Z1 N0 H1 C1.
- Robustness (WIDTH=16):
  - Pulse start in cycle 2 of an operation -> no effect.
  - Drop nreset in cycle 3 -> busy, done, result and all flags read 0 immediately.
  - No done follows the aborted operation; a fresh start after reset completes normally.

Source files
------------

// File: rtl/nibble_alu_seq.sv
// rtl/nibble_alu_seq.sv - nibble-serial SM83 accumulator ALU with start/busy/done handshake
module nibble_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             half_carry,
  output logic             carry
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             c_q;     // running carry/borrow between nibbles
  logic             h_q;     // carry/borrow out of nibble 0, kept for the H flag
  logic             nz_q;    // any computed nibble so far was non-zero
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       an;
  logic [3:0]       bn;
  logic [4:0]       sum5;
  logic [3:0]       wr_nib;
  logic             is_arith;
  logic             is_sub;
  logic             cout;
  logic             last;

  assign a_sh = a_q >> {cnt, 2'b00};
  assign b_sh = b_q >> {cnt, 2'b00};
  assign an   = a_sh[3:0];
  assign bn   = b_sh[3:0];
  assign last = (cnt == CW'(NIB - 1));

  // Nibble datapath: one 5-bit add/subtract or a bitwise op on the current nibble
  always_comb begin
    sum5     = 5'd0;
    is_arith = 1'b0;
    is_sub   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        sum5     = {1'b0, an} + {1'b0, bn} + {4'b0000, c_q};
        is_arith = 1'b1;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        sum5     = {1'b0, an} - {1'b0, bn} - {4'b0000, c_q};
        is_arith = 1'b1;
        is_sub   = 1'b1;
      end
      OP_AND:  sum5 = {1'b0, an & bn};
      OP_XOR:  sum5 = {1'b0, an ^ bn};
      OP_OR:   sum5 = {1'b0, an | bn};
      default: sum5 = 5'd0;
    endcase
    // CP keeps the accumulator: the difference only drives the flags
    wr_nib = (op_q == OP_CP) ? an : sum5[3:0];
    cout   = is_arith & sum5[4];
  end

  // Control FSM, operand latches, progressive result write and flag update
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      c_q        <= 1'b0;
      h_q        <= 1'b0;
      nz_q       <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      half_carry <= 1'b0;
      carry      <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) result[4*i +: 4] <= wr_nib;
          end
          c_q  <= cout;
          nz_q <= nz_q | (|sum5[3:0]);
          cnt  <= cnt + 1'b1;
          if (cnt == '0) h_q <= cout;
          if (last) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            carry      <= cout;
            negative   <= is_sub;
            zero       <= ~(nz_q | (|sum5[3:0]));
            // with a single nibble, H comes from this same edge's carry
            half_carry <= is_arith ? ((cnt == '0) ? cout : h_q) : (op_q == OP_AND);
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            c_q   <= ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b0;
            cnt   <= '0;
            nz_q  <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_alu_seq.sv
// tb/tb_nibble_alu_seq.sv - directed self-checking bench for nibble_alu_seq at WIDTH 8 and 16
module tb_nibble_alu_seq;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic        busy8, done8, zero8, neg8, half8, carry8;
  logic [7:0]  result8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
  logic        busy16, done16, zero16, neg16, half16, carry16;
  logic [15:0] result16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nibble_alu_seq #(.WIDTH(8)) u_alu8 (
    .clk(clk), .nreset(nreset), .start(start8), .op(op8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8), .negative(neg8),
    .half_carry(half8), .carry(carry8)
  );

  nibble_alu_seq #(.WIDTH(16)) u_alu16 (
    .clk(clk), .nreset(nreset), .start(start16), .op(op16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .result(result16), .zero(zero16), .negative(neg16),
    .half_carry(half16), .carry(carry16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request for one edge, then scramble the operand inputs
  task automatic issue(input bit s16, input logic [2:0] o, input logic [15:0] va,
                       input logic [15:0] vb, input logic ci);
    if (s16) begin
      start16 = 1'b1; op16 = o; a16 = va; b16 = vb; cin16 = ci;
    end else begin
      start8 = 1'b1; op8 = o; a8 = va[7:0]; b8 = vb[7:0]; cin8 = ci;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    op8 = 3'd5; op16 = 3'd5; cin8 = ~ci; cin16 = ~ci;
    a8 = 8'hA5; b8 = 8'h5A; a16 = 16'hBEEF; b16 = 16'hCAFE;
  endtask

  task automatic wait_done(input bit s16, input string tag, input int c0, input int lat);
    int cyc = c0;
    while (!(s16 ? done16 : done8) && cyc < 40) begin
      check({tag, " busy"}, {31'b0, s16 ? busy16 : busy8}, 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy at done"}, {31'b0, s16 ? busy16 : busy8}, 32'd0);
  endtask

  task automatic check_res(input bit s16, input string tag, input logic [15:0] er,
                           input logic [3:0] eznhc);
    check({tag, " result"}, {16'b0, s16 ? result16 : {8'h00, result8}}, {16'b0, er});
    check({tag, " flags znhc"},
          {28'b0, s16 ? {zero16, neg16, half16, carry16} : {zero8, neg8, half8, carry8}},
          {28'b0, eznhc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    #2;
    check("reset 8 outputs", {22'b0, busy8, done8, result8, zero8, neg8, half8, carry8}, 32'd0);
    check("reset 16 outputs", {10'b0, busy16, done16, result16, zero16, neg16, half16, carry16}, 32'd0);
    #10 nreset = 1'b1;
    @(posedge clk); #1;

    // WIDTH=8 vectors
    issue(0, 3'd0, 16'h3A, 16'hC6, 1'b0); wait_done(0, "add8", 1, 3); check_res(0, "add8", 16'h00, 4'b1011);
    issue(0, 3'd6, 16'h5A, 16'hA5, 1'b0); wait_done(0, "or8", 1, 3);  check_res(0, "or8", 16'hFF, 4'b0000);
    issue(0, 3'd4, 16'hF0, 16'h0F, 1'b0); wait_done(0, "and8 b2b", 1, 3); check_res(0, "and8 b2b", 16'h00, 4'b1010);
    issue(0, 3'd2, 16'h10, 16'h01, 1'b0); wait_done(0, "sub8", 1, 3); check_res(0, "sub8", 16'h0F, 4'b0110);
    issue(0, 3'd3, 16'h00, 16'h00, 1'b1); wait_done(0, "sbc8", 1, 3); check_res(0, "sbc8", 16'hFF, 4'b0111);
    issue(0, 3'd7, 16'h42, 16'h42, 1'b0); wait_done(0, "cp8 eq", 1, 3); check_res(0, "cp8 eq", 16'h42, 4'b1100);
    issue(0, 3'd7, 16'h10, 16'h20, 1'b0); wait_done(0, "cp8 lt", 1, 3); check_res(0, "cp8 lt", 16'h10, 4'b0101);
    issue(0, 3'd0, 16'h0F, 16'h01, 1'b1); wait_done(0, "add8 cin ignored", 1, 3); check_res(0, "add8 cin ignored", 16'h10, 4'b0010);
    issue(0, 3'd5, 16'hFF, 16'hFF, 1'b0); wait_done(0, "xor8", 1, 3); check_res(0, "xor8", 16'h00, 4'b1000);
    @(posedge clk); #1;
    check("xor8 done pulse ends", {31'b0, done8}, 32'd0);
    check_res(0, "xor8 hold", 16'h00, 4'b1000);

    // start pulsed in cycle 2 of a running operation must be ignored
    issue(1, 3'd0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    start16 = 1'b1; op16 = 3'd2; a16 = 16'hFFFF; b16 = 16'h0001;
    @(posedge clk); #1;
    start16 = 1'b0;
    wait_done(1, "add16 start ignored", 3, 5); check_res(1, "add16 start ignored", 16'h2345, 4'b0000);

    issue(1, 3'd1, 16'hFFFF, 16'h0000, 1'b1); wait_done(1, "adc16", 1, 5); check_res(1, "adc16", 16'h0000, 4'b1011);

    // asynchronous reset in cycle 3 aborts the operation
    issue(1, 3'd0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort16 partial result", {16'b0, result16}, 32'h0045);
    nreset = 1'b0;
    #1;
    check("abort16 cleared", {10'b0, busy16, done16, result16, zero16, neg16, half16, carry16}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) dn++;
    end
    check("abort16 no done afterwards", dn, 0);
    issue(1, 3'd2, 16'h0000, 16'h0001, 1'b0); wait_done(1, "sub16 after reset", 1, 5);
    check_res(1, "sub16 after reset", 16'hFFFF, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
